// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU opcode constants, datapath width
// and the barrel-shifter mode encoding.
package mips_pkg;

    localparam int DATA_W = 32;

    // AluCon operation codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    // Barrel shifter modes
    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit barrel shifter. Left shifts reuse the right-shift
// network by bit-reversing the operand on the way in and out.
module alu_shifter
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] dataIn,
    input  logic [4:0]        shiftAmt,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] dataOut
);

    logic                     isLeft;
    logic                     fillBit;
    logic [DATA_W-1:0]        inRev;
    logic [DATA_W-1:0]        outRev;
    logic [5:0][DATA_W-1:0]   stage;

    assign isLeft  = (mode == SHIFT_SLL);
    // Only arithmetic right shifts replicate the sign; everything else fills 0
    assign fillBit = (mode == SHIFT_SRA) & dataIn[DATA_W-1];

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_reverse
            assign inRev[gi]  = dataIn[DATA_W-1-gi];
            assign outRev[gi] = stage[5][DATA_W-1-gi];
        end
    endgenerate

    assign stage[0] = isLeft ? inRev : dataIn;

    // Five log-stages, stage gi shifts right by 2**gi when shiftAmt[gi] is set
    generate
        for (gi = 0; gi < 5; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stage[gi+1] = shiftAmt[gi]
                               ? {{SH{fillBit}}, stage[gi][DATA_W-1:SH]}
                               : stage[gi];
        end
    endgenerate

    assign dataOut = isLeft ? outRev : stage[5];

endmodule

// File: rtl/alu.sv
// 32-bit registered ALU for the MIPS execute stage. Result and zero flag
// are registered together, one cycle of latency, one operation per cycle.
module alu
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        AluCon,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] AluOut,
    output logic              Zero
);

    logic [DATA_W-1:0] resultNext;
    logic [DATA_W-1:0] aluOutReg;
    logic              zeroReg;
    logic [DATA_W-1:0] shiftOut;
    logic [1:0]        shiftMode;
    logic [DATA_W:0]   diffSigned;
    logic [DATA_W:0]   diffUnsigned;

    // 33-bit differences: bit 32 is the true sign (signed) or borrow
    // (unsigned), so SLT stays correct when the 32-bit subtract overflows.
    assign diffSigned   = {A[DATA_W-1], A} - {B[DATA_W-1], B};
    assign diffUnsigned = {1'b0, A} - {1'b0, B};

    // Select shifter mode from the opcode
    always_comb begin
        shiftMode = SHIFT_SLL;
        case (AluCon)
            ALU_SRL: shiftMode = SHIFT_SRL;
            ALU_SRA: shiftMode = SHIFT_SRA;
            default: shiftMode = SHIFT_SLL;
        endcase
    end

    alu_shifter u_shifter (
        .dataIn   (B),
        .shiftAmt (A[4:0]),
        .mode     (shiftMode),
        .dataOut  (shiftOut)
    );

    // Result mux; unused opcodes produce zero
    always_comb begin
        resultNext = '0;
        case (AluCon)
            ALU_AND:  resultNext = A & B;
            ALU_OR:   resultNext = A | B;
            ALU_ADD:  resultNext = A + B;
            ALU_XOR:  resultNext = A ^ B;
            ALU_SLL:  resultNext = shiftOut;
            ALU_SRL:  resultNext = shiftOut;
            ALU_SUB:  resultNext = diffUnsigned[DATA_W-1:0];
            ALU_SLT:  resultNext = {{(DATA_W-1){1'b0}}, diffSigned[DATA_W]};
            ALU_SLTU: resultNext = {{(DATA_W-1){1'b0}}, diffUnsigned[DATA_W]};
            ALU_SRA:  resultNext = shiftOut;
            ALU_LUI:  resultNext = {B[15:0], 16'h0000};
            ALU_NOR:  resultNext = ~(A | B);
            default:  resultNext = '0;
        endcase
    end

    // Output registers; result and flag load on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluOutReg <= '0;
            zeroReg   <= 1'b1;
        end else begin
            aluOutReg <= resultNext;
            zeroReg   <= (resultNext == '0);
        end
    end

    assign AluOut = aluOutReg;
    assign Zero   = zeroReg;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results into a queue,
// a monitor pops and compares one entry after each loading edge.
module tb_alu;
    import mips_pkg::*;

    typedef struct {
        logic [31:0] out;
        logic [3:0]  con;
        logic [31:0] a;
        logic [31:0] b;
    } expect_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  AluCon;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] AluOut;
    logic        Zero;

    expect_t     sbQueue[$];
    int          nVectors;
    int          nMiscompares;

    alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .AluCon (AluCon),
        .A      (A),
        .B      (B),
        .AluOut (AluOut),
        .Zero   (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written straight from the operation table
    function automatic logic [31:0] refAlu(input logic [3:0] con,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [4:0] sh;
        sh = a[4:0];
        case (con)
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_ADD:  return a + b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return b << sh;
            ALU_SRL:  return b >> sh;
            ALU_SUB:  return a - b;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_SRA:  return $unsigned($signed(b) >>> sh);
            ALU_LUI:  return {b[15:0], 16'h0000};
            ALU_NOR:  return ~(a | b);
            default:  return 32'd0;
        endcase
    endfunction

    // Drive one operation (caller is already at a negedge) and record its expectation
    task automatic driveOp(input logic [3:0] con, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expOut);
        expect_t e;
        AluCon = con;
        A      = a;
        B      = b;
        e.out  = expOut;
        e.con  = con;
        e.a    = a;
        e.b    = b;
        sbQueue.push_back(e);
    endtask

    task automatic stepOp(input logic [3:0] con, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expOut);
        @(negedge clk);
        driveOp(con, a, b, expOut);
    endtask

    task automatic checkDirect(input string name, input logic [31:0] expOut,
                               input logic expZero);
        nVectors++;
        if (AluOut !== expOut || Zero !== expZero) begin
            nMiscompares++;
            $display("FAIL %s: AluOut=%h Zero=%b, required AluOut=%h Zero=%b",
                     name, AluOut, Zero, expOut, expZero);
        end else begin
            $display("ok   %s: AluOut=%h Zero=%b", name, AluOut, Zero);
        end
    endtask

    // Monitor: each edge loaded out of reset retires the oldest expectation
    always @(posedge clk) begin
        expect_t e;
        logic    expZero;
        if (rst_n && sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            #1;
            expZero = (e.out == 32'd0);
            nVectors++;
            if (AluOut !== e.out || Zero !== expZero) begin
                nMiscompares++;
                $display("FAIL op=%b A=%h B=%h: AluOut=%h Zero=%b, required AluOut=%h Zero=%b",
                         e.con, e.a, e.b, AluOut, Zero, e.out, expZero);
            end else begin
                $display("ok   op=%b A=%h B=%h -> AluOut=%h Zero=%b",
                         e.con, e.a, e.b, AluOut, Zero);
            end
        end
    end

    initial begin
        logic [3:0]  con;
        logic [31:0] a;
        logic [31:0] b;
        int          waitCycles;

        nVectors     = 0;
        nMiscompares = 0;
        rst_n  = 1'b0;
        AluCon = ALU_ADD;
        A      = 32'd5;
        B      = 32'd7;

        // Reset holds outputs cleared while clocks run
        repeat (3) @(posedge clk);
        #1;
        checkDirect("reset_hold", 32'd0, 1'b1);

        // Release reset; the first edge loads 5 + 7
        @(negedge clk);
        rst_n = 1'b1;
        driveOp(ALU_ADD, 32'd5, 32'd7, 32'd12);

        // Directed operations from the test plan
        stepOp(ALU_AND,  32'd1,         32'd1,         32'd1);
        stepOp(ALU_NOR,  32'd0,         32'd0,         32'hFFFF_FFFF);
        stepOp(ALU_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0);
        stepOp(ALU_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE);
        stepOp(ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1);
        stepOp(ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0);
        stepOp(ALU_SLT,  32'h8000_0000, 32'd1,         32'd1);
        stepOp(ALU_SLT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        stepOp(ALU_SRA,  32'd4,         32'h8000_0000, 32'hF800_0000);
        stepOp(ALU_SRL,  32'd4,         32'h8000_0000, 32'h0800_0000);
        stepOp(ALU_SLL,  32'h0000_0021, 32'd1,         32'd2);
        stepOp(ALU_XOR,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd0);
        stepOp(4'b1101,  32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
        stepOp(ALU_OR,   32'd1,         32'd2,         32'd3);

        // Mid-stream reset: a nonzero result is loaded, then the next op is in flight
        stepOp(ALU_ADD, 32'd1, 32'd2, 32'd3);
        @(negedge clk);
        AluCon = ALU_OR;
        A      = 32'hFFFF_0000;
        B      = 32'h0000_00FF;
        #2;
        rst_n = 1'b0;
        #1;
        checkDirect("async_reset_clear", 32'd0, 1'b1);
        @(posedge clk);
        #1;
        checkDirect("reset_discards_inflight", 32'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        driveOp(ALU_LUI, 32'd0, 32'h0000_1234, 32'h1234_0000);

        // Back-to-back random operations; mid-cycle junk must not leak through
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            AluCon = 4'($urandom);
            A      = $urandom;
            B      = $urandom;
            #2;
            con = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 40));
                1:       a = 32'h8000_0000 | 32'($urandom_range(0, 3));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            driveOp(con, a, b, refAlu(con, a, b));
        end

        // Drain the scoreboard within a bounded number of cycles
        waitCycles = 0;
        while (sbQueue.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        #2;
        if (sbQueue.size() > 0) begin
            nMiscompares++;
            $display("FAIL drain: %0d results outstanding, required 0", sbQueue.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
